lock_code_sender: RTL and testbench

- Transmit side of the combination-lock button interface.
- Accepts an 8-bit code over a start/busy handshake and serialises it as four one-hot button strobes (2 bits per strobe), optionally preceded by a reprogram strobe.
- Then watches the lock's status lines and reports pass/fail.
- Used as the automated entry driver in front of the lock core, and as the stimulus engine in system-level benches.

---
 rtl/lock_pkg.sv | 34 +++
 rtl/lock_sym_encoder.sv | 24 ++
 rtl/lock_code_sender.sv | 168 ++++++++++++++++
 tb/tb_lock_code_sender.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock button interface:
// FSM states, symbol encodings and code geometry.
package lock_pkg;

  localparam int CODE_W       = 8;
  localparam int SYM_PER_CODE = 4;

  typedef enum logic [2:0] {
    IDLE,
    RE_PULSE,
    SYM_HI,
    SYM_GAP,
    WAIT_RESP,
    REPORT
  } state_t;

  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_10 = 2'b10;
  localparam logic [1:0] SYM_11 = 2'b11;

  // Symbol k is the pair (code[2k], code[2k+1]); the even bit is the MSB.
  function automatic logic [1:0] code_symbol(input logic [CODE_W-1:0] code,
                                             input logic [1:0]        k);
    return {code[{k, 1'b0}], code[{k, 1'b1}]};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_sym_encoder.sv
// Maps a 2-bit button symbol to the one-hot strobe vector {b4, b3, b2, b1}.
module lock_sym_encoder
  import lock_pkg::*;
(
  input  logic [1:0] sym,
  input  logic       en,
  output logic [3:0] strobe
);

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    strobe = '0;
    if (en) begin
      case (sym)
        SYM_00:  strobe = 4'b0001;
        SYM_01:  strobe = 4'b0010;
        SYM_10:  strobe = 4'b0100;
        SYM_11:  strobe = 4'b1000;
        default: strobe = '0;
      endcase
    end
  end

endmodule

// File: rtl/lock_code_sender.sv
// Transmit side of the lock button interface: sends a latched code as four
// one-hot strobes (optionally after a reprogram strobe) and reports pass/fail.
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int PULSE_W   = 1,
  parameter int GAP_W     = 2,
  parameter int RESP_WAIT = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  input  logic              prog,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              b1,
  output logic              b2,
  output logic              b3,
  output logic              b4,
  output logic              re_out,
  input  logic              unlocked_in,
  input  logic              reprog_in
);

  localparam int CNT_W = $clog2(max3(PULSE_W, GAP_W, RESP_WAIT) + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESP_WAIT - 1);
  localparam logic [1:0]       K_LAST     = 2'(SYM_PER_CODE - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        k;
  logic [CODE_W-1:0] code_q;
  logic              prog_q;
  logic              re_gap;
  logic              unlock_seen;
  logic [3:0]        strobe;

  logic [CODE_W-1:0] enc_code;
  logic [1:0]        enc_k;
  logic [1:0]        enc_sym;
  logic [3:0]        enc_strobe;

  // Symbol about to be loaded: k=0 on accept or after the reprogram gap,
  // otherwise the one following the current symbol.
  always_comb begin
    enc_code = (state == IDLE) ? code : code_q;
    enc_k    = (state == SYM_GAP && !re_gap) ? k + 2'd1 : 2'd0;
    enc_sym  = code_symbol(enc_code, enc_k);
  end

  lock_sym_encoder u_enc (
    .sym    (enc_sym),
    .en     (1'b1),
    .strobe (enc_strobe)
  );

  assign b1 = strobe[0];
  assign b2 = strobe[1];
  assign b3 = strobe[2];
  assign b4 = strobe[3];

  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: the latched code is cleared too, so an aborted transaction leaves nothing behind.
      state       <= IDLE;
      cnt         <= '0;
      k           <= '0;
      code_q      <= '0;
      prog_q      <= 1'b0;
      re_gap      <= 1'b0;
      unlock_seen <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      strobe      <= '0;
      re_out      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            code_q      <= code;
            prog_q      <= prog;
            busy        <= 1'b1;
            k           <= 2'd0;
            unlock_seen <= 1'b0;
            cnt         <= PULSE_LAST;
            if (prog) begin
              state  <= RE_PULSE;
              re_out <= 1'b1;
            end else begin
              state  <= SYM_HI;
              strobe <= enc_strobe;
            end
          end
        end

        RE_PULSE: begin
          if (cnt == '0) begin
            re_out <= 1'b0;
            re_gap <= 1'b1;
            cnt    <= GAP_LAST;
            state  <= SYM_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        SYM_HI: begin
          if (cnt == '0) begin
            strobe <= '0;
            cnt    <= GAP_LAST;
            state  <= SYM_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        SYM_GAP: begin
          if (cnt == '0) begin
            if (re_gap) begin
              re_gap <= 1'b0;
              k      <= 2'd0;
              strobe <= enc_strobe;
              cnt    <= PULSE_LAST;
              state  <= SYM_HI;
            end else if (k == K_LAST) begin
              cnt   <= RESP_LAST;
              state <= WAIT_RESP;
            end else begin
              k      <= k + 2'd1;
              strobe <= enc_strobe;
              cnt    <= PULSE_LAST;
              state  <= SYM_HI;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        WAIT_RESP: begin
          if (unlocked_in) unlock_seen <= 1'b1;
          if (cnt == '0) begin
            // Reprogram succeeds when the lock has left reprogram mode by the end.
            pass  <= prog_q ? !reprog_in : (unlock_seen | unlocked_in);
            done  <= 1'b1;
            state <= REPORT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_code_sender.sv
// Scoreboard bench for lock_code_sender: two instances (default and swept
// parameters) share stimulus; a reference model predicts every output cycle.
module tb_lock_code_sender;

  localparam int PW0 = 1, GW0 = 2, RW0 = 4;
  localparam int PW1 = 3, GW1 = 1, RW1 = 2;

  logic       clk = 1'b0;
  logic       clr, start, prog, unlocked_in, reprog_in;
  logic [7:0] code;
  logic [1:0] busy, done, pass, b1, b2, b3, b4, re_out;

  always #5 clk = ~clk;

  lock_code_sender #(.PULSE_W(PW0), .GAP_W(GW0), .RESP_WAIT(RW0)) dut0 (
    .clk(clk), .clr(clr), .start(start), .code(code), .prog(prog),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .b1(b1[0]), .b2(b2[0]), .b3(b3[0]), .b4(b4[0]), .re_out(re_out[0]),
    .unlocked_in(unlocked_in), .reprog_in(reprog_in)
  );

  lock_code_sender #(.PULSE_W(PW1), .GAP_W(GW1), .RESP_WAIT(RW1)) dut1 (
    .clk(clk), .clr(clr), .start(start), .code(code), .prog(prog),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .b1(b1[1]), .b2(b2[1]), .b3(b3[1]), .b4(b4[1]), .re_out(re_out[1]),
    .unlocked_in(unlocked_in), .reprog_in(reprog_in)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Per-cycle status inputs for the current transaction, indexed by cycle after accept.
  bit ul[64];
  bit rp[64];

  // Expected per-cycle {re_out, b4, b3, b2, b1}, plus length and pass per transaction.
  logic [4:0] sq0[$], sq1[$];
  int         lq0[$], lq1[$];
  bit         pq0[$], pq1[$];

  function automatic int pw(input bit id); return id ? PW1 : PW0; endfunction
  function automatic int gw(input bit id); return id ? GW1 : GW0; endfunction
  function automatic int rw(input bit id); return id ? RW1 : RW0; endfunction

  function automatic int txn_len(input bit id, input bit p);
    return (p ? pw(id) + gw(id) : 0) + 4 * (pw(id) + gw(id)) + rw(id);
  endfunction

  task automatic check(input string name, input bit id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got=%0h want=%0h at %0t", name, id, act, exp, $time);
    end
  endtask

  task automatic push_model(input bit id, input logic [7:0] c, input bit p);
    logic [4:0] seq[$];
    logic [7:0] sh;
    logic [1:0] pr;
    int         w0;
    bit         ps;
    if (p) begin
      repeat (pw(id)) seq.push_back(5'b10000);
      repeat (gw(id)) seq.push_back(5'b00000);
    end
    for (int s = 0; s < 4; s++) begin
      sh = c >> (2 * s);
      pr = {sh[0], sh[1]};
      repeat (pw(id)) seq.push_back(5'b00001 << pr);
      repeat (gw(id)) seq.push_back(5'b00000);
    end
    w0 = seq.size();
    repeat (rw(id)) seq.push_back(5'b00000);
    if (p) begin
      ps = !rp[w0 + rw(id)];
    end else begin
      ps = 1'b0;
      for (int t = w0 + 1; t <= w0 + rw(id); t++) ps = ps | ul[t];
    end
    foreach (seq[i]) begin
      if (id) sq1.push_back(seq[i]);
      else    sq0.push_back(seq[i]);
    end
    if (id) begin lq1.push_back(seq.size()); pq1.push_back(ps); end
    else    begin lq0.push_back(seq.size()); pq0.push_back(ps); end
  endtask

  // ---------------- monitor ----------------
  int  t_m[2], rem[2], len_c[2];
  bit  active[2], exp_pass_c[2], last_pass[2];
  bit  prev_clr = 1'b0;

  task automatic pop_s(input bit id, output logic [4:0] e);
    if (id) e = sq1.pop_front();
    else    e = sq0.pop_front();
  endtask

  task automatic pop_meta(input bit id, output int l, output bit p);
    if (id) begin l = lq1.pop_front(); p = pq1.pop_front(); end
    else    begin l = lq0.pop_front(); p = pq0.pop_front(); end
  endtask

  function automatic logic [4:0] strobes(input bit id);
    return {re_out[id], b4[id], b3[id], b2[id], b1[id]};
  endfunction

  task automatic mon(input bit id);
    logic [4:0] v, e;
    bit         empty;
    v = strobes(id);
    check("one_hot", id, 32'($onehot0(v)), 32'd1);
    if (prev_clr) begin
      check("after_clr", id, 32'({busy[id], done[id], pass[id], v}), 32'd0);
      while (rem[id] > 0) begin pop_s(id, e); rem[id]--; end
      active[id]    = 1'b0;
      last_pass[id] = 1'b0;
    end else begin
      if (!active[id] && busy[id]) begin
        empty = id ? (lq1.size() == 0) : (lq0.size() == 0);
        if (empty) begin
          check("unexpected_start", id, 32'(busy[id]), 32'd0);
        end else begin
          pop_meta(id, len_c[id], exp_pass_c[id]);
          active[id] = 1'b1;
          t_m[id]    = 0;
          rem[id]    = len_c[id];
        end
      end
      if (active[id]) begin
        t_m[id]++;
        if (t_m[id] <= len_c[id]) begin
          pop_s(id, e);
          rem[id]--;
          check("strobes", id, 32'(v), 32'(e));
          check("busy_done", id, 32'({busy[id], done[id]}), 32'b10);
        end else begin
          check("report", id, 32'({busy[id], done[id], v}), 32'b1100000);
          check("pass", id, 32'(pass[id]), 32'(exp_pass_c[id]));
          last_pass[id] = exp_pass_c[id];
          active[id]    = 1'b0;
        end
      end else begin
        check("idle", id, 32'({busy[id], done[id], pass[id], v}),
              32'({2'b00, last_pass[id], 5'b00000}));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
    prev_clr = clr;
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy != 2'b00 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", 1'b0, 32'(busy), 32'd0);
  endtask

  // mode: 0 random status, 1 unlocked high, 2 unlocked low, 3 reprog_in drops early
  task automatic send(input logic [7:0] c, input bit p, input int mode,
                      input int abort_at, input int spur_at);
    int lmax;
    wait_idle();
    for (int t = 0; t < 64; t++) begin
      case (mode)
        1:       begin ul[t] = 1'b1; rp[t] = 1'b1; end
        2:       begin ul[t] = 1'b0; rp[t] = 1'b1; end
        3:       begin ul[t] = 1'b0; rp[t] = (t < 10); end
        default: begin ul[t] = ($urandom_range(0, 7) == 0); rp[t] = 1'($urandom_range(0, 1)); end
      endcase
    end
    push_model(1'b0, c, p);
    push_model(1'b1, c, p);
    lmax = (txn_len(1'b0, p) > txn_len(1'b1, p)) ? txn_len(1'b0, p) : txn_len(1'b1, p);
    start = 1'b1; code = c; prog = p;
    unlocked_in = ul[0]; reprog_in = rp[0];
    @(posedge clk); #1;
    for (int t = 1; t <= lmax + 1; t++) begin
      if (abort_at != 0 && t > abort_at) break;
      unlocked_in = ul[t];
      reprog_in   = rp[t];
      clr         = (t == abort_at);
      start       = (t == spur_at);
      code        = (t == spur_at) ? 8'h55 : 8'($urandom);
      prog        = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    clr = 1'b0; start = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; prog = 1'b0; code = 8'h00;
    unlocked_in = 1'b0; reprog_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;

    send(8'hE4, 1'b0, 1, 0, 0);                               // basic send, pass
    send(8'h00, 1'b0, 2, 0, 0);                               // fail path
    send(8'hFF, 1'b1, 3, 0, 0);                               // reprogram
    send(8'hA6, 1'b0, 0, 0, PW0 + 1);                         // start during gap ignored
    send(8'h9C, 1'b0, 0, PW0 + GW0 + 1, 0);                   // clr in 2nd SYM_HI
    send(8'h39, 1'b0, 1, 0, 0);                               // full send after clr
    send(8'h1B, 1'b0, 1, 0, 0);                               // sweep pattern
    send(8'hC5, 1'b1, 0, 0, txn_len(1'b0, 1'b1) + 1);         // start in REPORT ignored
    send(8'h72, 1'b0, 0, 0, txn_len(1'b0, 1'b0) + 1);

    repeat (40) begin
      logic [7:0] c;
      bit         p;
      int         spur;
      c    = 8'($urandom);
      p    = 1'($urandom_range(0, 1));
      spur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, txn_len(1'b0, p)) : 0;
      send(c, p, 0, 0, spur);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("leftover0", 1'b0, 32'(lq0.size() + sq0.size()), 32'd0);
    check("leftover1", 1'b1, 32'(lq1.size() + sq1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
